// File: rtl/slow_clock_generator_prog.sv
// Runtime-programmable clock divider: new_clk = clk / (2*H), plus edge and mid-phase strobes.
// H is reloaded through a one-deep valid/ready slot, and only at the end of a high phase.
module slow_clock_generator_prog #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DEF_HALF = 250
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable_clk,
  input  logic [CNT_W-1:0] i_cfg_half_period,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  output logic [CNT_W-1:0] o_cur_half_period,
  output logic             o_new_clk,
  output logic             o_rising_edge,
  output logic             o_falling_edge,
  output logic             o_middle_of_high_level,
  output logic             o_middle_of_low_level
);

  localparam logic [CNT_W-1:0] DefHalf = CNT_W'(DEF_HALF);

  logic [CNT_W-1:0] r_cnt_q, r_cnt_d;
  logic [CNT_W-1:0] r_cur_half_q, r_cur_half_d;
  logic [CNT_W-1:0] r_pend_q, r_pend_d;
  logic             r_pend_valid_q, r_pend_valid_d;
  logic             r_new_clk_q, r_new_clk_d;
  logic             r_rise_q, r_rise_d;
  logic             r_fall_q, r_fall_d;
  logic             r_mid_high_q, r_mid_high_d;
  logic             r_mid_low_q, r_mid_low_d;

  logic w_accept;
  logic w_last;
  logic w_mid;

  assign w_accept = i_cfg_valid & ~r_pend_valid_q;
  assign w_last   = (r_cnt_q == r_cur_half_q - CNT_W'(1));
  assign w_mid    = (r_cnt_q == (r_cur_half_q >> 1));

  always_comb begin
    r_cnt_d        = r_cnt_q;
    r_cur_half_d   = r_cur_half_q;
    r_pend_d       = r_pend_q;
    r_pend_valid_d = r_pend_valid_q;
    r_new_clk_d    = r_new_clk_q;
    r_rise_d       = 1'b0;
    r_fall_d       = 1'b0;
    r_mid_high_d   = 1'b0;
    r_mid_low_d    = 1'b0;

    if (i_enable_clk) begin
      r_mid_high_d = r_new_clk_q & w_mid;
      r_mid_low_d  = ~r_new_clk_q & w_mid;
      if (w_last) begin
        r_cnt_d     = '0;
        r_new_clk_d = ~r_new_clk_q;
        r_rise_d    = ~r_new_clk_q;
        r_fall_d    = r_new_clk_q;
        // Reload only when a high phase ends, so the next low phase uses the new H in full.
        if (r_new_clk_q && r_pend_valid_q) begin
          r_cur_half_d   = r_pend_q;
          r_pend_valid_d = 1'b0;
        end
      end else begin
        r_cnt_d = r_cnt_q + CNT_W'(1);
      end
    end

    // Accept needs an empty slot, so it can never coincide with a reload from the slot.
    if (w_accept) begin
      r_pend_d       = (i_cfg_half_period == '0) ? CNT_W'(1) : i_cfg_half_period;
      r_pend_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_q        <= '0;
      r_cur_half_q   <= DefHalf;
      r_pend_q       <= '0;
      r_pend_valid_q <= 1'b0;
      r_new_clk_q    <= 1'b0;
      r_rise_q       <= 1'b0;
      r_fall_q       <= 1'b0;
      r_mid_high_q   <= 1'b0;
      r_mid_low_q    <= 1'b0;
    end else begin
      r_cnt_q        <= r_cnt_d;
      r_cur_half_q   <= r_cur_half_d;
      r_pend_q       <= r_pend_d;
      r_pend_valid_q <= r_pend_valid_d;
      r_new_clk_q    <= r_new_clk_d;
      r_rise_q       <= r_rise_d;
      r_fall_q       <= r_fall_d;
      r_mid_high_q   <= r_mid_high_d;
      r_mid_low_q    <= r_mid_low_d;
    end
  end

  assign o_cfg_ready            = ~r_pend_valid_q;
  assign o_cur_half_period      = r_cur_half_q;
  assign o_new_clk              = r_new_clk_q;
  assign o_rising_edge          = r_rise_q;
  assign o_falling_edge         = r_fall_q;
  assign o_middle_of_high_level = r_mid_high_q;
  assign o_middle_of_low_level  = r_mid_low_q;

endmodule

// File: tb/tb_slow_clock_generator_prog.sv
// Directed bench for slow_clock_generator_prog: a phase model fills a scoreboard each step,
// and spot checks pin the documented cycle positions of edges, strobes and reloads.
module tb_slow_clock_generator_prog;

  localparam int unsigned CntW = 16;
  localparam int unsigned DefH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            en = 1'b0;
  logic [CntW-1:0] cfg_half = '0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [CntW-1:0] cur_half;
  logic            new_clk, rise, fall, mid_high, mid_low;

  slow_clock_generator_prog #(
    .CNT_W   (CntW),
    .DEF_HALF(DefH)
  ) dut (
    .clk                   (clk),
    .reset                 (reset),
    .i_enable_clk          (en),
    .i_cfg_half_period     (cfg_half),
    .i_cfg_valid           (cfg_valid),
    .o_cfg_ready           (cfg_ready),
    .o_cur_half_period     (cur_half),
    .o_new_clk             (new_clk),
    .o_rising_edge         (rise),
    .o_falling_edge        (fall),
    .o_middle_of_high_level(mid_high),
    .o_middle_of_low_level (mid_low)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [21:0] sb_q[$];

  // Model: cycles elapsed in the current phase, phase level, H in force, pending slot.
  int unsigned m_elapsed = 0;
  int unsigned m_h       = DefH;
  int unsigned m_pend    = 0;
  bit          m_lvl     = 1'b0;
  bit          m_pv      = 1'b0;
  bit          m_rise, m_fall, m_mh, m_ml;

  task automatic model(input bit rst, input bit e, input bit v, input int unsigned d);
    bit ready_pre;
    ready_pre = !m_pv;
    m_rise = 0; m_fall = 0; m_mh = 0; m_ml = 0;
    if (rst) begin
      m_elapsed = 0; m_h = DefH; m_pv = 0; m_lvl = 0;
      return;
    end
    if (e) begin
      if (m_elapsed == (m_h / 2)) begin
        m_mh = m_lvl;
        m_ml = !m_lvl;
      end
      m_elapsed++;
      if (m_elapsed == m_h) begin
        m_elapsed = 0;
        m_rise = !m_lvl;
        m_fall = m_lvl;
        if (m_lvl && m_pv) begin
          m_h  = m_pend;
          m_pv = 0;
        end
        m_lvl = !m_lvl;
      end
    end
    if (v && ready_pre) begin
      m_pend = (d == 0) ? 1 : d;
      m_pv   = 1;
    end
  endtask

  task automatic step(input bit rst, input bit e, input bit v, input int unsigned d);
    logic [21:0] exp_v, obs_v;
    @(negedge clk);
    reset     = rst;
    en        = e;
    cfg_valid = v;
    cfg_half  = CntW'(d);
    model(rst, e, v, d);
    sb_q.push_back({!m_pv, CntW'(m_h), m_lvl, m_rise, m_fall, m_mh, m_ml});
    @(posedge clk);
    #1;
    cyc++;
    exp_v = sb_q.pop_front();
    obs_v = {cfg_ready, cur_half, new_clk, rise, fall, mid_high, mid_low};
    n_vec++;
    assert (obs_v === exp_v)
    else begin
      n_err++;
      $error("FAIL model_cyc%0d observed=%h expected=%h", cyc, obs_v, exp_v);
    end
  endtask

  task automatic chk(input string tag, input logic [CntW-1:0] obs, input logic [CntW-1:0] exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    int edges;
    int guard;

    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_new_clk", 16'(new_clk), 16'd0);
    chk("rst_cur_half", cur_half, 16'd4);
    chk("rst_ready", 16'(cfg_ready), 16'd1);
    chk("rst_strobes", 16'({rise, fall, mid_high, mid_low}), 16'd0);

    // Default H=4 from release: mid_low at clk3, rise at clk4, mid_high at clk7, fall at clk8
    repeat (3) step(0, 1, 0, 0);
    chk("clk3_mid_low", 16'(mid_low), 16'd1);
    step(0, 1, 0, 0);
    chk("clk4_rise", 16'({rise, new_clk, mid_low}), 16'b110);
    repeat (3) step(0, 1, 0, 0);
    chk("clk7_mid_high", 16'(mid_high), 16'd1);
    step(0, 1, 0, 0);
    chk("clk8_fall", 16'({fall, new_clk, mid_high}), 16'b100);

    // H=2 written at the start of a low phase, held off until the high phase ends
    step(0, 1, 1, 2);
    chk("cfg2_ready_low", 16'(cfg_ready), 16'd0);
    repeat (6) step(0, 1, 0, 0);
    chk("cfg2_still_pending", {15'd0, cfg_ready}, 16'd0);
    chk("cfg2_cur_old", cur_half, 16'd4);
    step(0, 1, 0, 0);
    chk("cfg2_applied", cur_half, 16'd2);
    chk("cfg2_ready_back", 16'({cfg_ready, fall}), 16'b11);
    repeat (2) step(0, 1, 0, 0);
    chk("h2_rise", 16'(rise), 16'd1);
    repeat (2) step(0, 1, 0, 0);
    chk("h2_fall", 16'(fall), 16'd1);

    // Zero requested -> H=1
    step(0, 1, 1, 0);
    repeat (3) step(0, 1, 0, 0);
    chk("h1_applied", cur_half, 16'd1);
    step(0, 1, 0, 0);
    chk("h1_rise_mid_low", 16'({new_clk, rise, fall, mid_high, mid_low}), 16'b11001);
    step(0, 1, 0, 0);
    chk("h1_fall_mid_high", 16'({new_clk, rise, fall, mid_high, mid_low}), 16'b00110);

    // H=3 with enable toggling every cycle
    step(0, 1, 1, 3);
    step(0, 1, 0, 0);
    chk("h3_applied", cur_half, 16'd3);
    edges = 0;
    for (int i = 0; i < 24; i++) begin
      step(0, (i % 2) == 0, 0, 0);
      if ((i % 2) != 0)
        chk($sformatf("dis_strobes_%0d", i), 16'({rise, fall, mid_high, mid_low}), 16'd0);
      if (rise || fall) edges++;
    end
    chk("h3_edge_count", 16'(edges), 16'd4);

    // Reset with a request pending while new_clk is high
    step(0, 1, 1, 5);
    guard = 0;
    while (!m_lvl && guard < 20) begin
      step(0, 1, 0, 0);
      guard++;
    end
    chk("pre_rst_high", 16'(new_clk), 16'd1);
    chk("pre_rst_pending", 16'(cfg_ready), 16'd0);
    step(1, 1, 0, 0);
    chk("post_rst", {new_clk, cfg_ready, cur_half[13:0]}, {2'b01, 14'd4});
    repeat (6) step(0, 1, 0, 0);
    chk("post_rst_cur", cur_half, 16'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
